shift_reg: RTL

Parametrised universal shift register, the multi-bit successor to the single-bit `bit` flip-flop. It holds a WIDTH-bit word and supports parallel load and clear, plus logical, rotate and arithmetic shifts by a programmable amount. A shift by N runs over N cycles with a start/busy/done handshake and a clock enable that can stall it. It serves as the datapath register for serializers and shift-based arithmetic.

---
 rtl/shift_reg_pkg.sv | 23 ++
 rtl/shift_reg_step.sv | 46 ++++
 rtl/shift_reg.sv | 113 +++++++++++
 3 files changed

// File: rtl/shift_reg_pkg.sv
// Shared mode codes, FSM encoding and helpers for the universal shift register.
package shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_LOAD = 3'd1;
  localparam logic [2:0] MODE_CLR  = 3'd2;
  localparam logic [2:0] MODE_SHL  = 3'd3;
  localparam logic [2:0] MODE_SHR  = 3'd4;
  localparam logic [2:0] MODE_ROL  = 3'd5;
  localparam logic [2:0] MODE_ROR  = 3'd6;
  localparam logic [2:0] MODE_ASR  = 3'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Modes 3..7 are the multi-cycle shift/rotate operations.
  function automatic logic is_shift(input logic [2:0] m);
    return (m >= MODE_SHL);
  endfunction

endpackage

// File: rtl/shift_reg_step.sv
// Combinational single-bit shift of a word, selected by mode.
module shift_step
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       mode_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             sin_i,
  output logic [WIDTH-1:0] word_o,
  output logic             bit_o
);

  // Next word and shifted-out bit for one step; non-shift modes pass through.
  always_comb begin
    word_o = word_i;
    bit_o  = 1'b0;
    case (mode_i)
      MODE_SHL: begin
        word_o = {word_i[WIDTH-2:0], sin_i};
        bit_o  = word_i[WIDTH-1];
      end
      MODE_SHR: begin
        word_o = {sin_i, word_i[WIDTH-1:1]};
        bit_o  = word_i[0];
      end
      MODE_ROL: begin
        word_o = {word_i[WIDTH-2:0], word_i[WIDTH-1]};
        bit_o  = word_i[WIDTH-1];
      end
      MODE_ROR: begin
        word_o = {word_i[0], word_i[WIDTH-1:1]};
        bit_o  = word_i[0];
      end
      MODE_ASR: begin
        word_o = {word_i[WIDTH-1], word_i[WIDTH-1:1]};
        bit_o  = word_i[0];
      end
      default: begin
        word_o = word_i;
        bit_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_reg.sv
// Universal shift register: load/clear plus multi-cycle shifts with handshake.
module shift_reg
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;

  logic [2:0]       step_mode;
  logic [WIDTH-1:0] step_word;
  logic             step_bit;

  // The first shift uses the live mode input; later shifts use the latched mode.
  assign step_mode = (state_q == ST_IDLE) ? mode : mode_q;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .mode_i (step_mode),
    .word_i (word_q),
    .sin_i  (sin),
    .word_o (step_word),
    .bit_o  (step_bit)
  );

  // Next-state logic: operation acceptance, shift sequencing and done pulse.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    if (en) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mode_d = mode;
            if (!is_shift(mode)) begin
              done_d = 1'b1;
              if (mode == MODE_LOAD) word_d = d;
              else if (mode == MODE_CLR) word_d = '0;
            end else if (amount == '0) begin
              done_d = 1'b1;
            end else begin
              word_d = step_word;
              sout_d = step_bit;
              if (amount == CNT_W'(1)) begin
                done_d = 1'b1;
              end else begin
                cnt_d   = amount - CNT_W'(1);
                state_d = ST_SHIFT;
              end
            end
          end
        end
        ST_SHIFT: begin
          word_d = step_word;
          sout_d = step_bit;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= MODE_HOLD;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  assign q    = word_q;
  assign sout = sout_q;
  assign busy = (state_q == ST_SHIFT);
  assign done = done_q;

endmodule
